// File: rtl/mc_defs.sv
// rtl/mc_defs.sv - shared opcodes, state encodings, select codes and control bundle
package mc_defs;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] S_IF     = 3'b000;
  localparam logic [2:0] S_ID     = 3'b001;
  localparam logic [2:0] S_EXE_LS = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB_LD  = 3'b100;
  localparam logic [2:0] S_EXE_BR = 3'b101;
  localparam logic [2:0] S_EXE_AL = 3'b110;
  localparam logic [2:0] S_WB_AL  = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JR   = 2'b10;
  localparam logic [1:0] PC_JMP  = 2'b11;

  typedef struct packed {
    logic       irwre;
    logic       pcwre;
    logic       insmemrw;
    logic       regwre;
    logic       alusrca;
    logic       alusrcb;
    logic [2:0] aluop;
    logic       extsel;
    logic       datamemrw;
    logic       dbdatasrc;
    logic [1:0] regdst;
    logic       wrregdsrc;
    logic [1:0] pcsrc;
  } ctrl_t;

  // Register-writing ALU instructions routed through sEXE_AL/sWB_AL.
  function automatic logic is_alu_op(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_OR) ||
           (op == OP_AND) || (op == OP_ORI) || (op == OP_SLL) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational (state, opcode, zero) to control-signal decode
// Ports: state_i current FSM state, opcode_i IR[31:26], zero_i ALU zero flag,
//        ctrl_o full control bundle (write enables not yet reset-gated).
module mc_ctrl_decode
  import mc_defs::*;
(
  input  logic [2:0] state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  output ctrl_t      ctrl_o
);

  logic jump_like;

  // j/jr/jal and any unrecognised opcode retire from sID.
  assign jump_like = !is_alu_op(opcode_i) && (opcode_i != OP_LW) && (opcode_i != OP_SW) &&
                     (opcode_i != OP_BEQ) && (opcode_i != OP_HALT);

  always_comb begin
    ctrl_o           = '0;
    ctrl_o.irwre     = (state_i == S_IF);
    ctrl_o.insmemrw  = (state_i == S_IF);

    ctrl_o.pcwre     = (state_i == S_WB_AL) || (state_i == S_WB_LD) || (state_i == S_EXE_BR) ||
                       ((state_i == S_MEM) && (opcode_i == OP_SW)) ||
                       ((state_i == S_ID) && jump_like);

    ctrl_o.regwre    = (state_i == S_WB_AL) || (state_i == S_WB_LD) ||
                       ((state_i == S_ID) && (opcode_i == OP_JAL));

    ctrl_o.datamemrw = (state_i == S_MEM) && (opcode_i == OP_SW);

    ctrl_o.alusrca   = (opcode_i == OP_SLL);
    ctrl_o.alusrcb   = (opcode_i == OP_ADDI) || (opcode_i == OP_ORI) ||
                       (opcode_i == OP_LW) || (opcode_i == OP_SW);
    ctrl_o.extsel    = (opcode_i != OP_ORI);
    ctrl_o.dbdatasrc = (opcode_i == OP_LW);
    ctrl_o.wrregdsrc = (opcode_i != OP_JAL);

    case (opcode_i)
      OP_SUB, OP_BEQ: ctrl_o.aluop = ALU_SUB;
      OP_OR, OP_ORI:  ctrl_o.aluop = ALU_OR;
      OP_AND:         ctrl_o.aluop = ALU_AND;
      OP_SLL:         ctrl_o.aluop = ALU_SLL;
      OP_SLT:         ctrl_o.aluop = ALU_SLT;
      default:        ctrl_o.aluop = ALU_ADD;
    endcase

    case (opcode_i)
      OP_JAL:                ctrl_o.regdst = 2'b00;
      OP_ADDI, OP_ORI, OP_LW: ctrl_o.regdst = 2'b01;
      default:               ctrl_o.regdst = 2'b10;
    endcase

    case (opcode_i)
      OP_BEQ:        ctrl_o.pcsrc = zero_i ? PC_BR : PC_NEXT;
      OP_JR:         ctrl_o.pcsrc = PC_JR;
      OP_J, OP_JAL:  ctrl_o.pcsrc = PC_JMP;
      default:       ctrl_o.pcsrc = PC_NEXT;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle control FSM with retired-instruction counter
// Ports: CLK/Reset (async active-low), opcode/zero in; state, datapath strobes and
//        selects out; instr_count counts PCWre pulses (one per retired instruction).
module mc_control_unit
  import mc_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic [2:0]       state,
  output logic             IRWre,
  output logic             PCWre,
  output logic             InsMemRW,
  output logic             RegWre,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             ExtSel,
  output logic             DataMemRW,
  output logic             DBDataSrc,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic [1:0]       PCSrc,
  output logic [CNT_W-1:0] instr_count
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            ctrl;

  mc_ctrl_decode u_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .zero_i   (zero),
    .ctrl_o   (ctrl)
  );

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (is_alu_op(opcode))                          state_d = S_EXE_AL;
        else if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_EXE_LS;
        else if (opcode == OP_BEQ)                       state_d = S_EXE_BR;
        else if (opcode == OP_HALT)                      state_d = S_ID;
        else                                             state_d = S_IF;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (opcode == OP_LW) ? S_WB_LD : S_IF;
      default:  state_d = S_IF;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (PCWre) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // State resets to sIF, whose decode would raise IRWre; gating with Reset
  // keeps every write enable low for the whole time reset is held.
  assign IRWre     = ctrl.irwre & Reset;
  assign PCWre     = ctrl.pcwre & Reset;
  assign RegWre    = ctrl.regwre & Reset;
  assign DataMemRW = ctrl.datamemrw & Reset;

  assign state       = state_q;
  assign instr_count = cnt_q;
  assign InsMemRW    = ctrl.insmemrw;
  assign ALUSrcA     = ctrl.alusrca;
  assign ALUSrcB     = ctrl.alusrcb;
  assign ALUOp       = ctrl.aluop;
  assign ExtSel      = ctrl.extsel;
  assign DBDataSrc   = ctrl.dbdatasrc;
  assign RegDst      = ctrl.regdst;
  assign WrRegDSrc   = ctrl.wrregdsrc;
  assign PCSrc       = ctrl.pcsrc;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - scoreboard bench for mc_control_unit
module tb_mc_control_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [5:0]  opcode;
  logic        zero;
  logic [2:0]  state;
  logic        IRWre, PCWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, ExtSel;
  logic        DataMemRW, DBDataSrc, WrRegDSrc;
  logic [2:0]  ALUOp;
  logic [1:0]  RegDst, PCSrc;
  logic [31:0] instr_count;

  mc_control_unit #(.CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .state(state),
    .IRWre(IRWre), .PCWre(PCWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
    .DataMemRW(DataMemRW), .DBDataSrc(DBDataSrc), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .PCSrc(PCSrc), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  st;
    logic        irwre, pcwre, regwre, dmrw, imrw;
    logic        chk_sel;
    logic [2:0]  aluop;
    logic        srca, srcb, ext;
    logic        chk_wb;
    logic [1:0]  regdst;
    logic        dbsrc, wrsrc;
    logic        chk_pc;
    logic [1:0]  pcsrc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;
  logic [31:0] model_cnt = 0;

  localparam int C_ALU = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_JMP = 4, C_UNK = 5, C_HALT = 6;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000,
      6'b010001, 6'b010010, 6'b011000, 6'b100110: return C_ALU;
      6'b110001: return C_LW;
      6'b110000: return C_SW;
      6'b110100: return C_BEQ;
      6'b111000, 6'b111001, 6'b111010: return C_JMP;
      6'b111111: return C_HALT;
      default:   return C_UNK;
    endcase
  endfunction

  // ALU operation named by each mnemonic (add/sub/or/and/sll/slt).
  function automatic logic [2:0] ref_aluop(input logic [5:0] op);
    case (op)
      6'b000001, 6'b110100: return 3'b001;
      6'b010000, 6'b010010: return 3'b010;
      6'b010001:            return 3'b011;
      6'b011000:            return 3'b100;
      6'b100110:            return 3'b101;
      default:              return 3'b000;
    endcase
  endfunction

  // Builds the per-cycle expectations of one instruction from its class.
  task automatic issue(input logic [5:0] op, input logic z, input int halt_cycles);
    int   cls;
    logic [2:0] path[$];
    exp_t e;
    cls = classify(op);
    case (cls)
      C_ALU:   path = '{3'b000, 3'b001, 3'b110, 3'b111};
      C_LW:    path = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
      C_SW:    path = '{3'b000, 3'b001, 3'b010, 3'b011};
      C_BEQ:   path = '{3'b000, 3'b001, 3'b101};
      default: path = '{3'b000, 3'b001};
    endcase
    if (cls == C_HALT) for (int k = 0; k < halt_cycles; k++) path.push_back(3'b001);
    for (int i = 0; i < path.size(); i++) begin
      bit last;
      last      = (i == path.size() - 1) && (cls != C_HALT);
      e         = '{default: '0};
      e.st      = path[i];
      e.irwre   = (i == 0);
      e.imrw    = (i == 0);
      e.pcwre   = last;
      e.regwre  = (last && (cls == C_ALU || cls == C_LW)) || (op == 6'b111010 && i == 1);
      e.dmrw    = last && (cls == C_SW);
      e.cnt     = model_cnt;
      e.chk_sel = (i >= 1) && (cls == C_ALU || cls == C_LW || cls == C_SW || cls == C_BEQ);
      e.aluop   = ref_aluop(op);
      e.srca    = (op == 6'b011000);
      e.srcb    = (op == 6'b000010 || op == 6'b010010 || cls == C_LW || cls == C_SW);
      e.ext     = (op != 6'b010010);
      e.chk_wb  = e.regwre;
      e.regdst  = (op == 6'b111010) ? 2'b00 :
                  (op == 6'b000010 || op == 6'b010010 || cls == C_LW) ? 2'b01 : 2'b10;
      e.dbsrc   = (cls == C_LW);
      e.wrsrc   = (op != 6'b111010);
      e.chk_pc  = last && (cls == C_BEQ || cls == C_JMP || cls == C_UNK);
      e.pcsrc   = (cls == C_BEQ) ? (z ? 2'b01 : 2'b00) :
                  (op == 6'b111001) ? 2'b10 :
                  (cls == C_JMP) ? 2'b11 : 2'b00;
      sb.push_back(e);
    end
    if (cls != C_HALT) model_cnt++;
    opcode = op;
    zero   = z;
    repeat (path.size()) @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        chk("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("IRWre", 32'(IRWre), 32'(e.irwre));
        chk("InsMemRW", 32'(InsMemRW), 32'(e.imrw));
        chk("PCWre", 32'(PCWre), 32'(e.pcwre));
        chk("RegWre", 32'(RegWre), 32'(e.regwre));
        chk("DataMemRW", 32'(DataMemRW), 32'(e.dmrw));
        chk("instr_count", instr_count, e.cnt);
        if (e.chk_sel) begin
          chk("ALUOp", 32'(ALUOp), 32'(e.aluop));
          chk("ALUSrcA", 32'(ALUSrcA), 32'(e.srca));
          chk("ALUSrcB", 32'(ALUSrcB), 32'(e.srcb));
          chk("ExtSel", 32'(ExtSel), 32'(e.ext));
        end
        if (e.chk_wb) begin
          chk("RegDst", 32'(RegDst), 32'(e.regdst));
          chk("DBDataSrc", 32'(DBDataSrc), 32'(e.dbsrc));
          chk("WrRegDSrc", 32'(WrRegDSrc), 32'(e.wrsrc));
        end
        if (e.chk_pc) chk("PCSrc", 32'(PCSrc), 32'(e.pcsrc));
      end
    end
  end

  function automatic logic [5:0] rand_op();
    logic [5:0] known[15];
    known = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
              6'b011000, 6'b100110, 6'b110000, 6'b110001, 6'b110100, 6'b111000,
              6'b111001, 6'b111010, 6'b101010};
    if ($urandom_range(0, 4) == 0) begin
      logic [5:0] r;
      do r = 6'($urandom); while (classify(r) != C_UNK);
      return r;
    end
    return known[$urandom_range(0, 14)];
  endfunction

  initial begin
    Reset  = 1'b0;
    opcode = 6'b000000;
    zero   = 1'b0;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_IRWre", 32'(IRWre), 32'd0);
    chk("rst_PCWre", 32'(PCWre), 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b1;
    #1;
    chk("rel_state", 32'(state), 32'd0);
    chk("rel_IRWre", 32'(IRWre), 32'd1);

    mon_en = 1;
    issue(6'b000000, 1'b0, 0);   // add
    issue(6'b110001, 1'b0, 0);   // lw
    issue(6'b110000, 1'b0, 0);   // sw
    issue(6'b110100, 1'b1, 0);   // beq taken
    issue(6'b110100, 1'b0, 0);   // beq not taken
    issue(6'b111010, 1'b0, 0);   // jal
    issue(6'b101010, 1'b0, 0);   // unknown -> nop
    for (int n = 0; n < 80; n++) issue(rand_op(), 1'($urandom), 0);
    mon_en = 0;
    chk("sb_drained_1", 32'(sb.size()), 32'd0);

    // Asynchronous reset asserted in the middle of sEXE_AL.
    opcode = 6'b000000;
    repeat (2) @(posedge CLK);
    #3;
    chk("mid_exe_state", 32'(state), 32'b110);
    Reset = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_RegWre", 32'(RegWre), 32'd0);
    chk("mid_rst_IRWre", 32'(IRWre), 32'd0);
    chk("mid_rst_count", instr_count, 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b1;
    #1;
    chk("rel2_state", 32'(state), 32'd0);
    chk("rel2_IRWre", 32'(IRWre), 32'd1);
    model_cnt = 0;

    mon_en = 1;
    issue(6'b000001, 1'b0, 0);   // sub
    issue(6'b111111, 1'b0, 24);  // halt, frozen in sID
    mon_en = 0;
    chk("sb_drained_2", 32'(sb.size()), 32'd0);
    chk("halt_state", 32'(state), 32'b001);
    chk("halt_count", instr_count, model_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle control FSM; sits directly downstream of the instruction register.
- Consumes the opcode field IR[31:26] and the ALU zero flag.
- Generates the IR write strobe, the PC write strobe and all datapath selects/enables.
- Sequences each instruction through IF/ID/EXE/MEM/WB states; also counts retired instructions for debug.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- CLK  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from ID onward
- zero  in  1  ALU zero flag (beq compare)
- state  out  3  current FSM state
- IRWre  out  1  instruction register write enable
- PCWre  out  1  PC write enable, one-cycle pulse per instruction
- InsMemRW  out  1  1 = instruction memory read
- RegWre  out  1  register file write enable
- ALUSrcA  out  1  1 = shamt, 0 = rs
- ALUSrcB  out  1  1 = extended immediate, 0 = rt
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 and, 100 sll, 101 slt
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend
- DataMemRW  out  1  1 = write data memory
- DBDataSrc  out  1  1 = memory data to writeback, 0 = ALU result
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DB data
- PCSrc  out  2  00 = PC+4, 01 = branch, 10 = jr rs, 11 = jump target
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
- States: sIF=000, sID=001, sEXE_LS=010, sMEM=011, sWB_LD=100, sEXE_BR=101, sEXE_AL=110, sWB_AL=111.
- state and instr_count are registered; all other outputs decode combinationally from (state, opcode, zero).
- Reset low, asynchronous: state=sIF, instr_count=0. Every write enable (IRWre, PCWre, RegWre, DataMemRW) forced to 0 while Reset is low, regardless of state.
- Transitions:
  - sIF->sID always.
  - sID->sEXE_AL for add/sub/addi/or/and/ori/sll/slt.
  - sID->sEXE_LS for lw/sw.
  - sID->sEXE_BR for beq.
  - sID->sIF for j/jr/jal and for unknown opcodes.
  - sID->sID for halt: frozen until reset.
  - sEXE_AL->sWB_AL->sIF.
  - sEXE_LS->sMEM.
  - sMEM->sWB_LD for lw; sMEM->sIF for sw.
  - sWB_LD->sIF.
  - sEXE_BR->sIF.
- Fetch strobes: IRWre=1 and InsMemRW=1 only in sIF. The IR captures on the edge leaving sIF, so opcode is valid in sID.
- PCWre=1 for exactly one cycle, in the last state of each instruction:
  - sWB_AL, sWB_LD;
  - sMEM for sw;
  - sEXE_BR;
  - sID for j/jr/jal/unknown.
  - PCWre=0 in sID for halt.
- instr_count increments on each rising edge where PCWre=1, wrapping modulo 2^CNT_W.
- Instruction cycle counts: R/I-type 4, lw 5, sw 4, beq 3, j/jr/jal 2, unknown 2 (treated as nop, PCSrc=00).
- RegWre=1 only in:
  - sWB_AL;
  - sWB_LD;
  - sID for jal (RegDst=00, WrRegDSrc=0).
- DataMemRW=1 only in sMEM for sw.
- beq: PCSrc=01 if zero else 00, sampled in sEXE_BR. ALUOp=001.
- ExtSel: 0 for ori, 1 otherwise.
- ALUSrcB=1 for addi/ori/lw/sw.
- ALUSrcA=1 for sll only.
- RegDst: 01 for I-type writes, 10 for R-type.
- DBDataSrc=1 only for lw.
- Outputs outside their active state are don't-care except write enables, which must be 0.

Decomposition:
- Package mc_defs holds: opcode localparams, state encodings, ALUOp and PCSrc codes.
- One sub-module, mc_ctrl_decode: purely combinational (state, opcode, zero) -> control outputs.
- The top holds the state register, next-state logic and instr_count.

Test Plan:
- Reset low mid-sEXE_AL -> state=000 immediately, RegWre=0. Reset release -> sIF, IRWre=1.
- add (opcode 000000) -> states 000,001,110,111,000. RegWre=1 only in 111 with RegDst=10. instr_count 0->1.
- lw then sw -> lw visits 011,100 with DBDataSrc=1, RegWre in 100. sw has DataMemRW=1 only in 011, then returns to 000. 9 cycles total.
- beq, zero=1 then zero=0 -> PCSrc=01 then 00 in state 101. PCWre high exactly one cycle each.
- jal -> sID has RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11. Next state 000.
- halt 111111 -> state sticks at 001 for 20+ cycles, PCWre=0, instr_count frozen. Unknown opcode 101010 -> 2-cycle nop.
